// File: rtl/hs_fifo_buf.sv
// hs_fifo_buf: DEPTH-entry FIFO between two four-phase REQ/ACK handshakes.
// Incoming REQ/ACK pass through SYNC_STAGES flops; all outputs are registered.
module hs_fifo_buf #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       StoB_REQ,
  input  logic [WIDTH-1:0]           DI,
  output logic                       BtoS_ACK,
  output logic                       BtoR_REQ,
  output logic [WIDTH-1:0]           DO,
  input  logic                       RtoB_ACK,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACK   = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_SETUP = 2'd1;
  localparam logic [1:0] R_REQ   = 2'd2;
  localparam logic [1:0] R_WAIT  = 2'd3;

  logic             req_s;
  logic             ack_s;

  logic [0:0]       sstate_q, sstate_d;
  logic [1:0]       rstate_q, rstate_d;
  logic             sack_q, sack_d;
  logic             rreq_q, rreq_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = StoB_REQ;
      assign ack_s = RtoB_ACK;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] rsync_q, rsync_d;
      logic [SYNC_STAGES-1:0] async_q, async_d;

      always_comb begin
        rsync_d = (rsync_q << 1) | SYNC_STAGES'(StoB_REQ);
        async_d = (async_q << 1) | SYNC_STAGES'(RtoB_ACK);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rsync_q <= '0;
          async_q <= '0;
        end else begin
          rsync_q <= rsync_d;
          async_q <= async_d;
        end
      end

      assign req_s = rsync_q[SYNC_STAGES-1];
      assign ack_s = async_q[SYNC_STAGES-1];
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    sstate_d = sstate_q;
    sack_d   = sack_q;
    push     = 1'b0;
    unique case (sstate_q)
      S_IDLE: begin
        if (req_s && !full) begin
          push     = 1'b1;
          sack_d   = 1'b1;
          sstate_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req_s) begin
          sack_d   = 1'b0;
          sstate_d = S_IDLE;
        end
      end
    endcase
  end

  // DO is loaded one cycle ahead of BtoR_REQ so the receiver sees settled data
  always_comb begin
    rstate_d = rstate_q;
    rreq_d   = rreq_q;
    dout_d   = dout_q;
    pop      = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (!empty && !ack_s) begin
          dout_d   = mem_q[rptr_q];
          rstate_d = R_SETUP;
        end
      end
      R_SETUP: begin
        rreq_d   = 1'b1;
        rstate_d = R_REQ;
      end
      R_REQ: begin
        if (ack_s) begin
          rreq_d   = 1'b0;
          pop      = 1'b1;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (!ack_s) rstate_d = R_IDLE;
      end
    endcase
  end

  always_comb begin
    wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sstate_q <= S_IDLE;
      rstate_q <= R_IDLE;
      sack_q   <= 1'b0;
      rreq_q   <= 1'b0;
      dout_q   <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      sstate_q <= sstate_d;
      rstate_q <= rstate_d;
      sack_q   <= sack_d;
      rreq_q   <= rreq_d;
      dout_q   <= dout_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= DI;
  end

  assign BtoS_ACK = sack_q;
  assign BtoR_REQ = rreq_q;
  assign DO       = dout_q;
  assign count    = count_q;

endmodule

// File: tb/tb_hs_fifo_buf.sv
// tb_hs_fifo_buf: directed and random checks of hs_fifo_buf
// against a queue-based model of the accepted words.
module tb_hs_fifo_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;

  logic         sreq;
  logic [W-1:0] di;
  logic         ack;
  logic         breq;
  logic [W-1:0] dout;
  logic         rack;
  logic [2:0]   cnt;

  logic         rx_auto;
  logic         rack_auto;
  logic         rack_man;

  logic         sreq1;
  logic [7:0]   di1;
  logic         ack1;
  logic         breq1;
  logic [7:0]   do1;
  logic         rack1;
  logic [0:0]   cnt1;

  int           total = 0;
  int           bad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] dlv[$];
  logic [W-1:0] sent[$];
  logic         prev_ack = 1'b0;
  logic         prev_breq = 1'b0;

  assign rack = rx_auto ? rack_auto : rack_man;

  always #5 clk = ~clk;

  hs_fifo_buf #(
    .WIDTH(W), .DEPTH(4), .SYNC_STAGES(2)
  ) u_dut (
    .clk(clk), .rst(rst),
    .StoB_REQ(sreq), .DI(di), .BtoS_ACK(ack),
    .BtoR_REQ(breq), .DO(dout), .RtoB_ACK(rack),
    .count(cnt)
  );

  hs_fifo_buf #(
    .WIDTH(8), .DEPTH(1), .SYNC_STAGES(0)
  ) u_dut1 (
    .clk(clk), .rst(rst),
    .StoB_REQ(sreq1), .DI(di1), .BtoS_ACK(ack1),
    .BtoR_REQ(breq1), .DO(do1), .RtoB_ACK(rack1),
    .count(cnt1)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model: words enter on an ACK rise, leave on a REQ fall.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
    end else begin
      if (ack && !prev_ack) begin
        check("ack_not_full", 64'(mq.size() < 4), 64'(1));
        mq.push_back(di);
      end
      if (breq) begin
        if (mq.size() == 0) check("do_without_word", 64'(0), 64'(1));
        else check("do_value", 64'(dout), 64'(mq[0]));
      end
      if (!breq && prev_breq && mq.size() != 0)
        dlv.push_back(mq.pop_front());
      check("count", 64'(cnt), 64'(mq.size()));
    end
    prev_ack  <= ack;
    prev_breq <= breq;
  end

  initial begin
    int n;
    rack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_auto && breq && !rack_auto) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rack_auto = 1'b1;
        n = 0;
        while (breq && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rack_auto = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ack(input logic v, input int lim, input string tag);
    int n = 0;
    while (ack !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(ack), 64'(v));
  endtask

  task automatic wait_breq(input logic v, input int lim, input string tag);
    int n = 0;
    while (breq !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(breq), 64'(v));
  endtask

  task automatic send_word(input logic [W-1:0] w);
    di   = w;
    sreq = 1'b1;
    wait_ack(1'b1, 40, "send_ack");
    sreq = 1'b0;
    wait_ack(1'b0, 40, "send_rel");
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((cnt != 0 || breq || rack) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(cnt), 64'(0));
    tick(4);
  endtask

  initial begin
    int base;
    rst = 1'b1; sreq = 1'b0; di = '0;
    rx_auto = 1'b0; rack_man = 1'b0;
    sreq1 = 1'b0; di1 = '0; rack1 = 1'b0;
    tick(2);
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_req", 64'(breq), 64'(0));
    check("rst_do", 64'(dout), 64'(0));
    check("rst_cnt", 64'(cnt), 64'(0));
    check("rst1_ack", 64'(ack1), 64'(0));
    check("rst1_req", 64'(breq1), 64'(0));
    check("rst1_do", 64'(do1), 64'(0));
    check("rst1_cnt", 64'(cnt1), 64'(0));

    // single word, exact edge timing
    rst = 1'b0; di = 32'h5; sreq = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("push_lat", 64'(ack), 64'(i == 3));
    end
    check("push_cnt", 64'(cnt), 64'(1));
    sreq = 1'b0;
    @(negedge clk);
    check("ft_do", 64'(dout), 64'(5));
    check("ft_req_lo", 64'(breq), 64'(0));
    @(negedge clk);
    check("ft_req_hi", 64'(breq), 64'(1));
    check("ack_hold", 64'(ack), 64'(1));
    @(negedge clk);
    check("ack_rel", 64'(ack), 64'(0));
    rack_man = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("pop_cnt", 64'(cnt), 64'((i == 3) ? 0 : 1));
    end
    check("pop_req", 64'(breq), 64'(0));
    rack_man = 1'b0;
    tick(4);

    // depth 1, no synchronisers
    di1 = 8'hA; sreq1 = 1'b1;
    @(negedge clk);
    check("d1_ack_lat", 64'(ack1), 64'(1));
    check("d1_cnt", 64'(cnt1), 64'(1));
    sreq1 = 1'b0;
    @(negedge clk);
    check("d1_do", 64'(do1), 64'(8'hA));
    check("d1_ack_rel", 64'(ack1), 64'(0));
    @(negedge clk);
    check("d1_req", 64'(breq1), 64'(1));
    di1 = 8'hB; sreq1 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("d1_stall", 64'(ack1), 64'(0));
    end
    rack1 = 1'b1;
    @(negedge clk);
    check("d1_pop", 64'(cnt1), 64'(0));
    check("d1_req_lo", 64'(breq1), 64'(0));
    @(negedge clk);
    check("d1_push2", 64'(ack1), 64'(1));
    check("d1_cnt2", 64'(cnt1), 64'(1));
    sreq1 = 1'b0; rack1 = 1'b0;
    for (int n = 0; n < 20 && !breq1; n++) @(negedge clk);
    check("d1_req2", 64'(breq1), 64'(1));
    check("d1_do2", 64'(do1), 64'(8'hB));
    rack1 = 1'b1;
    for (int n = 0; n < 20 && breq1; n++) @(negedge clk);
    check("d1_pop2", 64'(cnt1), 64'(0));
    rack1 = 1'b0;
    tick(3);

    // fill to DEPTH, stall the fifth word
    base = dlv.size();
    for (int i = 0; i < 4; i++) send_word(W'(i));
    check("fill_cnt", 64'(cnt), 64'(4));
    di = 32'd4; sreq = 1'b1;
    tick(10);
    check("stall_ack", 64'(ack), 64'(0));
    check("stall_cnt", 64'(cnt), 64'(4));
    check("stall_req", 64'(breq), 64'(1));
    rack_man = 1'b1;
    wait_breq(1'b0, 20, "stall_pop");
    rack_man = 1'b0;
    wait_ack(1'b1, 20, "stall_release");
    check("refill_cnt", 64'(cnt), 64'(4));
    sreq = 1'b0;
    wait_ack(1'b0, 20, "stall_ack_rel");
    rx_auto = 1'b1;
    drain(400);
    rx_auto = 1'b0;
    check("fill_n", 64'(dlv.size()), 64'(base + 5));
    for (int i = 0; i < 5 && base + i < dlv.size(); i++)
      check("fill_order", 64'(dlv[base+i]), 64'(i));

    // push and pop on the same edge at count 2
    send_word(32'hA0);
    send_word(32'hA1);
    wait_breq(1'b1, 20, "sim_req");
    check("sim_pre_cnt", 64'(cnt), 64'(2));
    di = 32'hA2; sreq = 1'b1; rack_man = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("sim_cnt", 64'(cnt), 64'(2));
    end
    check("sim_ack", 64'(ack), 64'(1));
    check("sim_pop", 64'(breq), 64'(0));
    sreq = 1'b0; rack_man = 1'b0;
    wait_ack(1'b0, 20, "sim_ack_rel");
    rx_auto = 1'b1;
    drain(400);

    // wrap-around stream 0..9
    base = dlv.size();
    for (int i = 0; i < 10; i++) begin
      send_word(W'(i));
      tick($urandom_range(0, 2));
    end
    drain(400);
    check("wrap_n", 64'(dlv.size()), 64'(base + 10));
    for (int i = 0; i < 10 && base + i < dlv.size(); i++)
      check("wrap_order", 64'(dlv[base+i]), 64'(i));

    // random words, random gaps on both sides
    base = dlv.size();
    sent.delete();
    for (int i = 0; i < 40; i++) begin
      sent.push_back($urandom);
      send_word(sent[i]);
      tick($urandom_range(0, 6));
    end
    drain(800);
    check("rand_n", 64'(dlv.size()), 64'(base + 40));
    for (int i = 0; i < 40 && base + i < dlv.size(); i++)
      check("rand_order", 64'(dlv[base+i]), 64'(sent[i]));
    rx_auto = 1'b0;
    tick(4);

    // reset in the middle of a transfer
    send_word(32'd77);
    wait_breq(1'b1, 20, "mr_req");
    di = 32'd88; sreq = 1'b1;
    tick(3);
    check("mr_pre_ack", 64'(ack), 64'(1));
    check("mr_pre_cnt", 64'(cnt), 64'(2));
    rst = 1'b1;
    @(negedge clk);
    check("mr_ack", 64'(ack), 64'(0));
    check("mr_req0", 64'(breq), 64'(0));
    check("mr_cnt", 64'(cnt), 64'(0));
    check("mr_do", 64'(dout), 64'(0));
    rst = 1'b0;
    base = dlv.size();
    wait_ack(1'b1, 10, "mr_new_xfer");
    check("mr_new_cnt", 64'(cnt), 64'(1));
    sreq = 1'b0;
    wait_ack(1'b0, 20, "mr_ack_rel");
    rx_auto = 1'b1;
    drain(200);
    check("mr_n", 64'(dlv.size()), 64'(base + 1));
    if (dlv.size() > base) check("mr_word", 64'(dlv[base]), 64'(88));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
